// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings,
// default operand width and the bit-counter sizing rule.
package sub_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter must index WIDTH bits, but never collapse to zero width.
    function automatic int cnt_width(input int w);
        if (w > 1) begin
            return $clog2(w);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/fsb.sv
// Combinational full-subtract cell: one bit of a - b - borrow.
module fsb (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bo
);

    assign D  = A ^ B ^ Bin;
    assign Bo = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: captures a, b, bin on start, then resolves one
// bit per clock LSB first and publishes d/bo with a single-cycle done.
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_nxt_s;
    logic             br_r;
    logic [WIDTH-1:0] d_r;
    logic             bo_r;
    logic             done_r;
    logic             busy_r;
    logic             bit_d_s;
    logic             bit_bo_s;
    logic             last_s;
    logic             load_s;
    logic             shift_s;

    fsb u_fsb (
        .A   (a_r[0]),
        .B   (b_r[0]),
        .Bin (br_r),
        .D   (bit_d_s),
        .Bo  (bit_bo_s)
    );

    // New difference bit enters from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_nxt_s = bit_d_s;
        end else begin : g_res_many
            assign res_nxt_s = {bit_d_s, res_r[WIDTH-1:1]};
        end
    endgenerate

    // Detect the final serial step.
    always_comb begin
        if (cnt_r == CNT_LAST) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM control decode: operand load in IDLE, one shift per RUN edge.
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            ST_IDLE: load_s  = start;
            ST_RUN:  shift_s = 1'b1;
            default: begin
                load_s  = 1'b0;
                shift_s = 1'b0;
            end
        endcase
    end

    // Datapath, borrow flop and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
            br_r   <= 1'b0;
            d_r    <= '0;
            bo_r   <= 1'b0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (load_s) begin
                a_r    <= a;
                b_r    <= b;
                br_r   <= bin;
                cnt_r  <= '0;
                res_r  <= '0;
                busy_r <= 1'b1;
            end else if (shift_s) begin
                a_r   <= a_r >> 1'b1;
                b_r   <= b_r >> 1'b1;
                res_r <= res_nxt_s;
                br_r  <= bit_bo_s;
                cnt_r <= cnt_r + CW'(1);
                if (last_s) begin
                    d_r    <= res_nxt_s;
                    bo_r   <= bit_bo_s;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end else begin
                    busy_r <= 1'b1;
                end
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign d    = d_r;
    assign bo   = bo_r;

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits, legal range 1..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 SHALL have port a, input, WIDTH, minuend; captured on an accepted start.
REQ-006 SHALL have port b, input, WIDTH, subtrahend; captured on an accepted start.
REQ-007 SHALL have port bin, input, 1, borrow-in; captured on an accepted start.
REQ-008 SHALL have port busy, output, 1, high while a subtraction is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking a new valid result.
REQ-010 SHALL have port d, output, WIDTH, difference: (a - b - bin) mod 2^WIDTH.
REQ-011 SHALL have port bo, output, 1, borrow-out: 1 exactly when a < b + bin.

Function
REQ-012 SHALL implement two states: IDLE and RUN.
REQ-013 In IDLE, start=1 at edge T0 SHALL be accepted: load a, b, and bin; clear the bit counter; enter RUN; set busy=1.
REQ-014 In RUN, start SHALL be ignored, and changes on a, b, or bin SHALL have no effect.
REQ-015 Each RUN edge SHALL process one bit, LSB first, through the full-subtract cell.
- Bit output: ai ^ bi ^ br.
- Next borrow: (~ai & bi) | (~(ai ^ bi) & br).
- The bit output shifts into the result register from the MSB side.
- The operand registers shift right by one.
REQ-016 The counter SHALL be $clog2(WIDTH) bits wide, minimum 1; RUN SHALL last exactly WIDTH edges (T1..T_WIDTH).
REQ-017 At edge T_WIDTH the block SHALL:
- load d with the completed result and bo with the final borrow;
- set done=1 for exactly one cycle;
- clear busy;
- return to IDLE.
REQ-018 Latency SHALL be WIDTH cycles, from the start-accept edge to done high; throughput is one operation per WIDTH+1 cycles.
REQ-019 d and bo SHALL hold the previous result for the whole of RUN and change only at a done edge.
REQ-020 start=1 in the cycle where done=1 SHALL be accepted: the state is IDLE, and back-to-back operations are legal.
REQ-021 A held start SHALL begin a new operation on every IDLE edge; no edge detection.
REQ-022 When a < b + bin, d SHALL wrap modulo 2^WIDTH and bo SHALL be 1.
REQ-023 WIDTH=1 SHALL work: one RUN edge, then done.

Reset
REQ-024 While rst_n=0, the block SHALL immediately, independent of clk, force:
- state=IDLE;
- busy=0, done=0, d=0, bo=0;
- counter, operand, result, and borrow registers to 0.
REQ-025 Reset asserted in RUN SHALL abort the operation; no done SHALL be produced for it.
REQ-026 After release, the first start SHALL be accepted on the first rising edge at which rst_n=1.

Structure
REQ-027 State encodings (IDLE, RUN) and the WIDTH default SHALL live in shared package sub_pkg.
REQ-028 The per-bit logic SHALL be instantiated as combinational sub-module fsb.
- Ports: A, B, Bin, D, Bo.
- It is the team's existing full-subtractor cell and SHALL NOT be re-coded inline.
REQ-029 The borrow flip-flop, the shift registers, and the FSM SHALL reside in serial_sub.

Verification
REQ-030 The bench SHALL cover these directed cases (WIDTH=8 unless stated):
- V1: a=0x05, b=0x03, bin=0, start at T0 -> busy high T0..T8; done high one cycle after T8; d=0x02, bo=0.
- V2: a=0x03, b=0x05, bin=0 -> d=0xFE, bo=1.
- V3: a=0x00, b=0x00, bin=1 -> d=0xFF, bo=1. Also a=0xFF, b=0xFF, bin=0 -> d=0x00, bo=0.
- V4: new start with a=0x10 at T3 while busy -> ignored; the V1 result and timing are unchanged, and exactly one done is seen.
- V5: rst_n low at T4 of an operation -> outputs zero immediately, no done. A start after release with a=0x09, b=0x04 -> d=0x05.
- V6: WIDTH=4 -> all 512 (a, b, bin) combinations run back-to-back (start during done); each result matches the arithmetic model; done interval is 5 cycles.
